// File: rtl/i2s_pkg.sv
// Shared constants, sample types and slot helper for the I2S transmitter.
// Used by i2s_clk_gen and i2s_audio_tx.
package i2s_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int SLOTS_PER_CH = 32;
    localparam int SLOT_W       = $clog2(SLOTS_PER_CH);

    localparam logic [SLOT_W-1:0] DELAY_SLOT      = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] FIRST_DATA_SLOT = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] LAST_DATA_SLOT  = SLOT_W'(16);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_sample_t;

    // Serial bit carried by a slot: delay slot, MSB-first data, then zero pad.
    function automatic logic slot_bit(input sample_t word,
                                      input logic [SLOT_W-1:0] slot);
        logic [SLOT_W-1:0] idx;
        idx = LAST_DATA_SLOT - slot;
        if (slot != DELAY_SLOT && slot >= FIRST_DATA_SLOT &&
            slot <= LAST_DATA_SLOT)
            return |(word & sample_t'(32'd1 << idx));
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running I2S clock counter; MCLK/SCK/LRCK are direct flop bits.
// Also provides frame-load and SCK-fall strobes plus the current slot index.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int SCK_BIT  = 4,
    parameter int MCLK_BIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mclk,
    output logic              sck,
    output logic              lrck,
    output logic              frame_load,
    output logic              sck_fall,
    output logic [SLOT_W-1:0] slot
);

    localparam int LRCK_BIT = SCK_BIT + 6;

    logic [LRCK_BIT:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign mclk       = cnt[MCLK_BIT];
    assign sck        = cnt[SCK_BIT];
    assign lrck       = cnt[LRCK_BIT];
    assign slot       = cnt[LRCK_BIT-1:SCK_BIT+1];
    assign frame_load = &cnt;
    assign sck_fall   = &cnt[SCK_BIT:0];

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo transmitter: one-pair holding buffer feeding a serial shift pair.
// Optional I2S_TX_VOLUME_EN adds a vol port applying an arithmetic right shift.
module i2s_audio_tx
    import i2s_pkg::*;
#(
    parameter int SCK_BIT  = 4,
    parameter int MCLK_BIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
`ifdef I2S_TX_VOLUME_EN
    input  logic [2:0]          vol,
`endif
    output logic                in_ready,
    output logic                underrun,
    output logic                mclk,
    output logic                sck,
    output logic                lrck,
    output logic                sdin
);

    stereo_sample_t    hold;
    stereo_sample_t    shift;
    stereo_sample_t    scaled;
    logic              hold_full;
    logic              frame_load;
    logic              sck_fall;
    logic              accept;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W:0]   next_pos;

    i2s_clk_gen #(
        .SCK_BIT (SCK_BIT),
        .MCLK_BIT(MCLK_BIT)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mclk      (mclk),
        .sck       (sck),
        .lrck      (lrck),
        .frame_load(frame_load),
        .sck_fall  (sck_fall),
        .slot      (slot)
    );

    assign in_ready = !hold_full;
    assign accept   = in_valid && !hold_full;
    assign underrun = frame_load && !hold_full;
    // Channel and slot that begin right after the coming SCK fall.
    assign next_pos = {lrck, slot} + 1'b1;

`ifdef I2S_TX_VOLUME_EN
    assign scaled.left  = $signed(hold.left) >>> vol;
    assign scaled.right = $signed(hold.right) >>> vol;
`else
    assign scaled = hold;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold      <= '0;
        end else if (accept) begin
            hold      <= '{left: in_left, right: in_right};
            hold_full <= 1'b1;
        end else if (en && frame_load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            shift <= '0;
            sdin  <= 1'b0;
        end else begin
            if (frame_load && hold_full)
                shift <= scaled;
            if (sck_fall)
                sdin <= slot_bit(next_pos[SLOT_W] ? shift.right : shift.left,
                                 next_pos[SLOT_W-1:0]);
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Randomised self-checking bench for i2s_audio_tx against a frame-level model.
// Build with +define+I2S_TX_VOLUME_EN to also exercise the vol port.
module tb_i2s_audio_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_ready;
    logic        underrun;
    logic        mclk;
    logic        sck;
    logic        lrck;
    logic        sdin;
`ifdef I2S_TX_VOLUME_EN
    logic [2:0]  vol = '0;
`endif

    int          c;
    int          tests;
    int          fails;
    int          und_cnt;
    int          acc_obs;
    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    logic [15:0] play_l;
    logic [15:0] play_r;
    logic [15:0] cap;
    logic [15:0] last_l;
    logic [15:0] last_r;
    logic [15:0] prev_l;

    always #5 clk = ~clk;

    i2s_audio_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_valid(in_valid),
        .in_left (in_left),
        .in_right(in_right),
`ifdef I2S_TX_VOLUME_EN
        .vol     (vol),
`endif
        .in_ready(in_ready),
        .underrun(underrun),
        .mclk    (mclk),
        .sck     (sck),
        .lrck    (lrck),
        .sdin    (sdin)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, c);
        end
    endtask

    function automatic logic [15:0] scale(input logic [15:0] x);
`ifdef I2S_TX_VOLUME_EN
        return 16'($signed(x) >>> vol);
`else
        return x;
`endif
    endfunction

    // Expected pins for position n = c mod 2048 within the current frame.
    task automatic check_outputs();
        int          n;
        int          s;
        int          ch;
        logic [15:0] w;
        logic        e;
        n  = c % 2048;
        s  = (n / 32) % 32;
        ch = n / 1024;
        w  = (ch != 0) ? play_r : play_l;
        e  = (s >= 1 && s <= 16) ? w[16-s] : 1'b0;
        chk("mclk", mclk, (n / 2) % 2);
        chk("sck", sck, (n / 16) % 2);
        chk("lrck", lrck, ch);
        chk("sdin", sdin, e);
        chk("in_ready", in_ready, q_l.size() == 0);
        chk("underrun", underrun, n == 2047 && q_l.size() == 0);
        if (underrun) und_cnt++;
        if (n % 32 == 16 && s >= 1 && s <= 16) begin
            cap = (s == 1) ? {15'b0, sdin} : {cap[14:0], sdin};
            if (s == 16) begin
                chk(ch != 0 ? "word_r" : "word_l", cap, w);
                if (ch != 0) last_r = cap;
                else last_l = cap;
            end
        end
    endtask

    task automatic step(input logic v, input logic [15:0] l,
                        input logic [15:0] r);
        bit acc;
        check_outputs();
        if (v && in_ready) acc_obs++;
        in_valid = v;
        in_left  = l;
        in_right = r;
        if (!rst_n) begin
            c = 0;
            q_l.delete();
            q_r.delete();
            play_l = '0;
            play_r = '0;
        end else begin
            acc = v && q_l.size() == 0;
            if (en && c % 2048 == 2047 && q_l.size() > 0) begin
                play_l = scale(q_l.pop_front());
                play_r = scale(q_r.pop_front());
            end
            if (acc) begin
                q_l.push_back(l);
                q_r.push_back(r);
            end
            if (!en) begin
                c      = 0;
                play_l = '0;
                play_r = '0;
            end else begin
                c++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        c = 0;
        play_l = '0;
        play_r = '0;
        cap = '0;
        last_l = '0;
        last_r = '0;
        @(negedge clk);

        // Idle frames: clocks run, underrun every frame, sdin silent
        do_reset();
        und_cnt = 0;
        run(4096);
        chk("idle_underruns", und_cnt, 2);
        chk("idle_word", last_l, 16'h0000);

        // Single sample accepted at cycle 10
        do_reset();
        while (c < 4096) step(c == 10, 16'hA5C3, 16'h0001);
        chk("a5c3_left", last_l, 16'hA5C3);
        chk("a5c3_right", last_r, 16'h0001);

        // Source always valid: one accept per frame, no underrun
        und_cnt = 0;
        acc_obs = 0;
        for (int i = 0; i < 5 * 2048; i++)
            step(1'b1, 16'($urandom), 16'($urandom));
        chk("stream_underruns", und_cnt, 0);
        chk("stream_accepts", acc_obs, 5);

        // Sample arriving on the frame-load cycle with empty buffer
        for (int i = 0; i < 2048 && c % 2048 != 2047; i++) run(1);
        chk("late_underrun", underrun, 1);
        prev_l = play_l;
        step(1'b1, 16'h7E81, 16'h8118);
        run(2048);
        chk("repeat_left", last_l, prev_l);
        run(2048);
        chk("late_left", last_l, 16'h7E81);
        chk("late_right", last_r, 16'h8118);

        // Reset in the middle of the right channel discards everything
        for (int i = 0; i < 2048 && c % 2048 != 1500; i++)
            step(c % 2048 == 5, 16'h1234, 16'h5678);
        rst_n = 1'b0;
        step(1'b0, '0, '0);
        rst_n = 1'b1;
        chk("rst_lrck", lrck, 0);
        chk("rst_sdin", sdin, 0);
        chk("rst_ready", in_ready, 1);
        und_cnt = 0;
        run(4096);
        chk("rst_underruns", und_cnt, 2);
        chk("rst_word", last_l, 16'h0000);

`ifdef I2S_TX_VOLUME_EN
        vol = 3'd2;
        while (c % 2048 != 0) run(1);
        for (int i = 0; i < 4096; i++) step(i == 10, 16'h8000, 16'h4000);
        chk("vol_left", last_l, 16'hE000);
        chk("vol_right", last_r, 16'h1000);
`endif

        // Random traffic with occasional run-enable drops
        for (int i = 0; i < 16384; i++) begin
`ifdef I2S_TX_VOLUME_EN
            if (i % 500 == 0) vol = 3'($urandom);
`endif
            if ($urandom_range(0, 2999) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 40));
                en = 1'b1;
            end
            step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
